// File: rtl/arms_counter_pkg.sv
// Shared command encodings and direction type for the arms limit counter.
package arms_counter_pkg;

    localparam logic [1:0] CMD_LOAD  = 2'b00;
    localparam logic [1:0] CMD_LIMIT = 2'b01;
    localparam logic [1:0] CMD_UP    = 2'b10;
    localparam logic [1:0] CMD_DOWN  = 2'b11;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/arms_prescaler.sv
// Divides enabled cycles down to one count tick every PRESCALE enabled cycles.
module arms_prescaler #(
    parameter int unsigned PRESCALE = 1,
    parameter int unsigned PS_W     = 8
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] cnt_q;
    logic [PS_W-1:0] cnt_d;

    // Tick is decoded combinationally so the counter can act on the same edge.
    always_comb begin
        tick  = en && (cnt_q == PS_LAST);
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + PS_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/arms_counter_p.sv
// Strobe-programmed up/down limit counter with reload/wrap mode, prescaler and status flags.
module arms_counter_p
    import arms_counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned PRESCALE = 1,
    parameter int unsigned PS_W     = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             STRB,
    input  logic [1:0]       CON,
    input  logic [WIDTH-1:0] DATA,
    input  logic             WRAP,
    input  logic             CEN,
    output logic [WIDTH-1:0] COUT,
    output logic             TC,
    output logic             DONE,
    output logic             BUSY
);

    logic [WIDTH-1:0] cout_q, cout_d;
    logic [WIDTH-1:0] rld_q,  rld_d;
    logic [WIDTH-1:0] lim_q,  lim_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             tc_q,   tc_d;
    logic             wrap_q, wrap_d;
    dir_e             dir_q,  dir_d;

    logic             ps_clr;
    logic             ps_en;
    logic             tick;
    logic [WIDTH-1:0] next_cnt;

    // A strobe cycle never advances the prescaler, so a coincident tick is dropped.
    assign ps_clr = STRB && CON[1];
    assign ps_en  = busy_q && CEN && !STRB;

    arms_prescaler #(
        .PRESCALE (PRESCALE),
        .PS_W     (PS_W)
    ) u_prescaler (
        .CLK  (CLK),
        .RST  (RST),
        .clr  (ps_clr),
        .en   (ps_en),
        .tick (tick)
    );

    assign next_cnt = (dir_q == DIR_UP) ? cout_q + WIDTH'(1) : cout_q - WIDTH'(1);

    always_comb begin
        cout_d = cout_q;
        rld_d  = rld_q;
        lim_d  = lim_q;
        busy_d = busy_q;
        done_d = done_q;
        tc_d   = 1'b0;
        wrap_d = wrap_q;
        dir_d  = dir_q;
        if (STRB) begin
            case (CON)
                CMD_LOAD: begin
                    cout_d = DATA;
                    rld_d  = DATA;
                    busy_d = 1'b0;
                    done_d = 1'b0;
                end
                CMD_LIMIT: begin
                    lim_d = DATA;
                end
                default: begin
                    dir_d  = (CON == CMD_DOWN) ? DIR_DOWN : DIR_UP;
                    wrap_d = WRAP;
                    if (cout_q == lim_q) begin
                        busy_d = 1'b0;
                        done_d = 1'b1;
                        tc_d   = 1'b1;
                    end else begin
                        busy_d = 1'b1;
                        done_d = 1'b0;
                    end
                end
            endcase
        end else if (tick) begin
            if (next_cnt != lim_q) begin
                cout_d = next_cnt;
            end else if (wrap_q) begin
                cout_d = rld_q;
                tc_d   = 1'b1;
            end else begin
                cout_d = lim_q;
                busy_d = 1'b0;
                done_d = 1'b1;
                tc_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cout_q <= '0;
            rld_q  <= '0;
            lim_q  <= '1;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            tc_q   <= 1'b0;
            wrap_q <= 1'b0;
            dir_q  <= DIR_UP;
        end else begin
            cout_q <= cout_d;
            rld_q  <= rld_d;
            lim_q  <= lim_d;
            busy_q <= busy_d;
            done_q <= done_d;
            tc_q   <= tc_d;
            wrap_q <= wrap_d;
            dir_q  <= dir_d;
        end
    end

    assign COUT = cout_q;
    assign TC   = tc_q;
    assign DONE = done_q;
    assign BUSY = busy_q;

endmodule

// File: tb/tb_arms_counter_p.sv
// Directed test of arms_counter_p with PRESCALE=1 and PRESCALE=3 instances driven in parallel.
module tb_arms_counter_p;

    logic       clk = 1'b0;
    logic       rst;
    logic       strb;
    logic [1:0] con;
    logic [3:0] data;
    logic       wrap;
    logic       cen;

    logic [3:0] cout1, cout3;
    logic       tc1, done1, busy1;
    logic       tc3, done3, busy3;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    arms_counter_p #(.WIDTH(4), .PRESCALE(1), .PS_W(8)) u_dut1 (
        .CLK(clk), .RST(rst), .STRB(strb), .CON(con), .DATA(data), .WRAP(wrap), .CEN(cen),
        .COUT(cout1), .TC(tc1), .DONE(done1), .BUSY(busy1)
    );

    arms_counter_p #(.WIDTH(4), .PRESCALE(3), .PS_W(8)) u_dut3 (
        .CLK(clk), .RST(rst), .STRB(strb), .CON(con), .DATA(data), .WRAP(wrap), .CEN(cen),
        .COUT(cout3), .TC(tc3), .DONE(done3), .BUSY(busy3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks the PRESCALE=1 instance status in one go.
    task automatic chk1(input string tag, input logic [3:0] c, input logic b,
                        input logic d, input logic t);
        chk({tag, ".cout"}, 32'(cout1), 32'(c));
        chk({tag, ".busy"}, 32'(busy1), 32'(b));
        chk({tag, ".done"}, 32'(done1), 32'(d));
        chk({tag, ".tc"},   32'(tc1),   32'(t));
    endtask

    task automatic chk3(input string tag, input logic [3:0] c, input logic b,
                        input logic d, input logic t);
        chk({tag, ".cout"}, 32'(cout3), 32'(c));
        chk({tag, ".busy"}, 32'(busy3), 32'(b));
        chk({tag, ".done"}, 32'(done3), 32'(d));
        chk({tag, ".tc"},   32'(tc3),   32'(t));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One strobed command; operands are scrambled afterwards since they must be ignored.
    task automatic cmd(input logic [1:0] c, input logic [3:0] d, input logic w);
        strb = 1'b1;
        con  = c;
        data = d;
        wrap = w;
        step();
        strb = 1'b0;
        con  = 2'(c + 2'd1);
        data = 4'hA;
        wrap = ~w;
    endtask

    initial begin
        logic [3:0] exp_c;
        logic [3:0] wrap_seq [8];
        logic [3:0] ps_seq [8];
        logic       cen_seq [8];

        rst  = 1'b1;
        strb = 1'b1;
        con  = 2'b10;
        data = 4'h7;
        wrap = 1'b0;
        cen  = 1'b1;
        step();
        chk1("reset1", 4'd0, 1'b0, 1'b0, 1'b0);
        chk3("reset3", 4'd0, 1'b0, 1'b0, 1'b0);
        rst  = 1'b0;
        strb = 1'b0;

        // Basic up run to limit 9
        cmd(2'b00, 4'd3, 1'b0);
        chk1("load3", 4'd3, 1'b0, 1'b0, 1'b0);
        cmd(2'b01, 4'd9, 1'b0);
        cmd(2'b10, 4'd0, 1'b0);
        chk1("start_up", 4'd3, 1'b1, 1'b0, 1'b0);
        for (int i = 4; i <= 8; i++) begin
            step();
            chk1("up_step", 4'(i), 1'b1, 1'b0, 1'b0);
        end
        step();
        chk1("up_end", 4'd9, 1'b0, 1'b1, 1'b1);
        step();
        chk1("up_hold", 4'd9, 1'b0, 1'b1, 1'b0);

        // Wrap down between 12 and limit 8
        cmd(2'b00, 4'd12, 1'b0);
        chk1("load12", 4'd12, 1'b0, 1'b0, 1'b0);
        cmd(2'b01, 4'd8, 1'b0);
        cmd(2'b11, 4'd0, 1'b1);
        wrap_seq = '{4'd11, 4'd10, 4'd9, 4'd12, 4'd11, 4'd10, 4'd9, 4'd12};
        for (int i = 0; i < 8; i++) begin
            step();
            chk1("wrap_dn", wrap_seq[i], 1'b1, 1'b0, wrap_seq[i] == 4'd12);
        end

        // Load aborts the running wrap
        cmd(2'b00, 4'd5, 1'b0);
        chk1("abort_load", 4'd5, 1'b0, 1'b0, 1'b0);
        step();
        chk1("abort_hold", 4'd5, 1'b0, 1'b0, 1'b0);

        // Up from 15 with limit 1 passes through 0
        cmd(2'b00, 4'd15, 1'b0);
        cmd(2'b01, 4'd1, 1'b0);
        cmd(2'b10, 4'd0, 1'b0);
        step();
        chk1("wrap0_a", 4'd0, 1'b1, 1'b0, 1'b0);
        step();
        chk1("wrap0_b", 4'd1, 1'b0, 1'b1, 1'b1);
        step();
        chk1("wrap0_c", 4'd1, 1'b0, 1'b1, 1'b0);

        // Start with count already on the limit
        cmd(2'b00, 4'd5, 1'b0);
        chk1("eq_load", 4'd5, 1'b0, 1'b0, 1'b0);
        cmd(2'b01, 4'd5, 1'b0);
        cmd(2'b10, 4'd0, 1'b0);
        chk1("eq_start", 4'd5, 1'b0, 1'b1, 1'b1);
        step();
        chk1("eq_after", 4'd5, 1'b0, 1'b1, 1'b0);

        // Down from 0 with limit 14
        cmd(2'b00, 4'd0, 1'b0);
        cmd(2'b01, 4'd14, 1'b0);
        cmd(2'b11, 4'd0, 1'b0);
        step();
        chk1("dn0_a", 4'd15, 1'b1, 1'b0, 1'b0);
        step();
        chk1("dn0_b", 4'd14, 1'b0, 1'b1, 1'b1);

        // Limit lowered below count mid-run; the strobe also swallows a tick
        cmd(2'b00, 4'd0, 1'b0);
        cmd(2'b01, 4'd15, 1'b0);
        cmd(2'b10, 4'd0, 1'b0);
        step();
        step();
        step();
        chk1("lowlim_pre", 4'd3, 1'b1, 1'b0, 1'b0);
        cmd(2'b01, 4'd2, 1'b0);
        chk1("lowlim_strb", 4'd3, 1'b1, 1'b0, 1'b0);
        exp_c = 4'd3;
        for (int i = 0; i < 14; i++) begin
            step();
            exp_c = exp_c + 4'd1;
            chk1("lowlim_run", exp_c, 1'b1, 1'b0, 1'b0);
        end
        step();
        chk1("lowlim_end", 4'd2, 1'b0, 1'b1, 1'b1);

        // Reset in the middle of a wrap run
        cmd(2'b00, 4'd0, 1'b0);
        cmd(2'b01, 4'd9, 1'b0);
        cmd(2'b10, 4'd0, 1'b1);
        step();
        step();
        chk1("rst_pre", 4'd2, 1'b1, 1'b0, 1'b0);
        rst  = 1'b1;
        strb = 1'b1;
        con  = 2'b00;
        data = 4'd7;
        step();
        rst  = 1'b0;
        strb = 1'b0;
        chk1("rst_mid1", 4'd0, 1'b0, 1'b0, 1'b0);
        chk3("rst_mid3", 4'd0, 1'b0, 1'b0, 1'b0);

        // PRESCALE=3: load 0, limit 2, start at edge k
        cmd(2'b00, 4'd0, 1'b0);
        cmd(2'b01, 4'd2, 1'b0);
        cmd(2'b10, 4'd0, 1'b0);
        chk3("ps_start", 4'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            step();
            chk3("ps_run", (i >= 3) ? 4'd1 : 4'd0, 1'b1, 1'b0, 1'b0);
        end
        step();
        chk3("ps_end", 4'd2, 1'b0, 1'b1, 1'b1);

        // PRESCALE=3 with CEN low for two edges: run stretches by two
        cmd(2'b00, 4'd0, 1'b0);
        cmd(2'b10, 4'd0, 1'b0);
        cen_seq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        ps_seq  = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2};
        for (int i = 0; i < 7; i++) begin
            cen = cen_seq[i];
            step();
            chk3("ps_cen", ps_seq[i], 1'b1, 1'b0, 1'b0);
        end
        cen = cen_seq[7];
        step();
        chk3("ps_cen_end", ps_seq[7], 1'b0, 1'b1, 1'b1);
        step();
        chk3("ps_cen_hold", 4'd2, 1'b0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/arms_counter_p.md
Name: arms_counter_p

Overview:
Parametrised successor of the strobe-programmed limit counter, fully synchronous to CLK.
- A 2-bit command, qualified by STRB, loads the count, loads the limit, or starts counting up or down toward the limit.
- New relative to the first generation: parametrised WIDTH; start value doubles as reload value; optional wrap (auto-reload) mode; clock prescaler; pause input; TC/DONE/BUSY status.
- Sits between the control-register decoder and timer/event logic.

Parameters:
WIDTH, 4, width of DATA, count, limit and reload registers
PRESCALE, 1, count tick every PRESCALE enabled CLK cycles (>=1)
PS_W, 8, width of internal prescaler counter (PRESCALE <= 2**PS_W)

Ports:
CLK  input  1  single clock; all state updates on rising edge
RST  input  1  synchronous, active-high reset
STRB  input  1  command valid, sampled high at a rising CLK edge (level, one command per high cycle)
CON  input  2  command: 00 load count, 01 load limit, 10 count up, 11 count down
DATA  input  WIDTH  operand for CON=00 and CON=01
WRAP  input  1  wrap mode, latched with a start command (CON=1x)
CEN  input  1  count enable; 0 freezes prescaler and counter, BUSY is held
COUT  output  WIDTH  current count
TC  output  1  one-cycle pulse on limit match (stop or wrap)
DONE  output  1  sticky: a non-wrap run ended on the limit
BUSY  output  1  counting active

Behaviour:
- Reset (RST=1 at edge): COUT=0, RLD=0, LIM=all ones, BUSY=0, DONE=0, TC=0, DIR=up, WRAP latch=0, prescaler=0. RST overrides STRB.
- Commands take effect at the edge where STRB=1. Visible the next cycle (one-cycle latency).
- CON=00: COUT<=DATA, RLD<=DATA, BUSY<=0, DONE<=0. This aborts any run. DATA=0 gives the legacy clear.
- CON=01: LIM<=DATA. Allowed mid-run; later ticks compare against the new limit. BUSY/DONE unchanged.
- CON=10/11: DIR<=up/down, WRAP latched, prescaler<=0, DONE<=0.
  - If COUT==LIM at that edge: BUSY stays 0, DONE<=1, TC pulses next cycle.
  - Otherwise BUSY<=1.
  - A start while BUSY restarts the run with the new direction and mode.
- Tick: asserted when BUSY and CEN and prescaler==PRESCALE-1; the prescaler then returns to 0.
  - The prescaler increments only when BUSY and CEN.
  - With PRESCALE=1, every enabled cycle is a tick. After a start at edge k, the first count change is at edge k+PRESCALE (CEN held high).
- On a tick, NEXT = COUT+1 (up) or COUT-1 (down), modulo 2**WIDTH. Wrap-around through 0 / all ones is legal.
  - NEXT!=LIM: COUT<=NEXT.
  - NEXT==LIM, wrap off: COUT<=LIM, BUSY<=0, DONE<=1, TC<=1.
  - NEXT==LIM, wrap on: COUT<=RLD, TC<=1, BUSY stays 1. The period is the modular distance RLD->LIM in ticks.
- TC is high for exactly one cycle per match event; otherwise 0.
- Precedence: RST > STRB command > tick. A tick coinciding with STRB is discarded; the prescaler is not advanced.
- CEN=0 mid-run: COUT, prescaler and BUSY are frozen. STRB commands still execute.
- DATA, CON and WRAP are ignored when STRB=0.

Decomposition:
- Shared package arms_counter_pkg:
  - CON encodings CMD_LOAD=2'b00, CMD_LIMIT=2'b01, CMD_UP=2'b10, CMD_DOWN=2'b11
  - direction constant DIR_UP/DIR_DOWN
- One sub-module, arms_prescaler (PRESCALE, PS_W; inputs CLK, RST, clr, en; output tick).
- Compare/update logic and status flags stay in arms_counter_p.

Test Plan:
- WIDTH=4, PRESCALE=1. STRB CON=00 DATA=3, then CON=01 DATA=9, then CON=10 WRAP=0 with CEN=1. Required: COUT steps 4..9 on successive edges; BUSY drops and TC pulses the cycle COUT=9; DONE=1 and COUT holds 9.
- Wrap down: load 12, limit 8, CON=11 WRAP=1. Required: COUT 11,10,9,12,11,10,9,12..., with a TC pulse at each reload to 12; BUSY stays 1.
- PRESCALE=3: load 0, limit 2, CON=10 at edge k. Required: COUT=1 at k+3 and 2 at k+6; TC at k+6. Drop CEN for 2 cycles mid-run and the run stretches by exactly 2 cycles.
- Boundaries:
  - Load 15, limit 1, count up. Required: COUT 0 then 1, then stop.
  - Start with COUT==LIM=5. Required: BUSY=0, DONE=1, single TC.
  - Count down from 0 with limit 14. Required: 15, 14, stop.
- Mid-operation events, each in its own run:
  - CON=01 DATA lowered below COUT mid-run. Required: counting continues via modulo wrap to the new limit.
  - CON=00 mid-run. Required: BUSY=0 next cycle and COUT=DATA.
  - STRB coincident with a tick. Required: the command result only.
  - RST asserted mid-run. Required: all outputs at reset values the next cycle.
